mem_arb_ctrl: RTL and testbench
===============================

// Module: mem_arb_ctrl
// PURPOSE
//  Parametrised byte-serial memory controller: NCH requesters (IF, LSU, ...) share one 8-bit RAM/IO port.
//  Each channel issues 1/2/4-byte loads/stores; one transaction at a time, with configurable arbitration and RAM read latency.
//  Sits between the CPU core's fetch/memory stages and the top-level RAM/IO bus; replaces the fixed 2-client controller.
// PARAMETERS
//  NCH      2   number of request channels (>=1); channel 0 highest fixed priority
//  ADDR_W   32  address width
//  RD_LAT   1   cycles from mem_addr_o/mem_wr=0 to valid mem_din (>=1)
//  RR       0   0 = fixed priority, 1 = round-robin among requesters
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          synchronous reset, active-high
//  req_i        in   NCH        per-channel request level
//  we_i         in   NCH        per-channel 1=store, 0=load
//  addr_i       in   NCH*ADDR_W per-channel byte address (ch k at [k*ADDR_W +: ADDR_W])
//  wdata_i      in   NCH*32     per-channel store data, LSB first to memory
//  len_i        in   NCH*3      per-channel length in bytes: 1, 2 or 4
//  rdata_o      out  32         load data, zero-extended; valid when any done_o bit is high
//  done_o       out  NCH        one-cycle completion pulse, one-hot
//  busy_o       out  1          transaction in progress
//  io_buffer_full in 1          stalls store byte issue while high
//  mem_din      in   8          RAM read byte
//  mem_dout     out  8          RAM write byte
//  mem_addr_o   out  ADDR_W     RAM byte address
//  mem_wr       out  1          1=write strobe for this cycle, 0=read
// BEHAVIOUR
//  Reset: all outputs 0 (mem_wr=Read, done_o=0, rdata_o=0, busy_o=0), FSM->IDLE, RR pointer->0; takes effect next edge,
//   aborts any transaction mid-flight; no further write strobes after the reset edge.
//  FSM: IDLE -> RD | WR -> IDLE; DONE is not a state: done_o pulses on the edge returning to IDLE.
//  IDLE: eligible = req_i & ~done_q (channel done last cycle is masked one cycle, requester must drop req).
//   Grant: RR=0 lowest index; RR=1 first eligible index after last granted (wrap NCH-1->0). Latch we/addr/wdata/len.
//   Illegal len (0,3,5-7): no memory access, done_o[ch]=1 next cycle, rdata_o=0.
//  RD (len L): mem_addr_o=addr+k, mem_wr=0 for k=0..L-1 on consecutive cycles starting the grant edge;
//   byte k sampled RD_LAT cycles after its address into bits [8k+7:8k]; upper bytes 0.
//   done_o/rdata_o asserted L+RD_LAT cycles after grant edge; mem_addr_o returns to 0 after last address.
//  RD abort: granted channel drops req_i before done -> stop issuing, discard in-flight bytes, IDLE next edge, no done_o.
//  WR (len L): byte k = wdata[8k+7:8k] to addr+k with mem_wr=1, one per cycle when io_buffer_full=0;
//   io_buffer_full=1 -> that cycle mem_wr=0, mem_addr_o=0, index held (stall, unbounded).
//   done_o after last byte strobe; req_i drop during WR ignored (no partial stores).
//  mem_wr=1 only in WR cycles actually issuing a byte; mem_dout=0 otherwise.
//  Address adds wrap modulo 2^ADDR_W. rdata_o holds last value between pulses.
//  busy_o=1 from grant edge until the edge that asserts done_o or aborts.
// STRUCTURE
//  defines.v: len encodings (LEN_B=1, LEN_H=2, LEN_W=4), Read/Write, True/False, ZeroWord, LenBus.
//  Sub-module mem_arb_rr (NCH-wide fixed/round-robin grant, one-hot out, pointer update on grant).
//  Read pipeline: RD_LAT-deep shift of {valid,byte index,tag}; abort clears valids.
// TESTING
//  T1 ch1 load len=4 @0x100, RAM[0x100..103]=11,22,33,44, RD_LAT=1 -> done_o=2'b10 at grant+5, rdata_o=0x44332211.
//  T2 ch0 store len=2 @0x20 wdata=0xBEEF, io_buffer_full high 3 cycles after 1st byte -> writes EF@0x20, EF stall, BE@0x21, one done.
//  T3 req ch0 and ch1 same cycle, RR=0 -> ch0 served first, ch1 granted the cycle after ch0's done; RR=1 repeated -> alternating grants.
//  T4 ch1 load len=4, drop req after 2 cycles -> no done_o, next ch0 request granted next cycle with correct data.
//  T5 rst asserted mid-store at byte 1 of 4 -> next edge mem_wr=0, all outputs 0, no further bytes written.
//  T6 len=3 request -> done_o one cycle later, rdata_o=0, mem_wr never 1; RD_LAT=3 load len=1 -> done at grant+4.

Source files
------------

// File: rtl/mem_arb_ctrl_pkg.sv
// Shared types and constants for the byte-serial multi-channel memory controller.
package mem_arb_ctrl_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LEN_BITS = 3;
  localparam int unsigned CNT_W    = 3;

  localparam logic [LEN_BITS-1:0] LEN_B = 3'd1;
  localparam logic [LEN_BITS-1:0] LEN_H = 3'd2;
  localparam logic [LEN_BITS-1:0] LEN_W = 3'd4;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEN_BITS-1:0] len;
    logic [WORD_W-1:0]   wdata;
  } txn_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rd_tag_t;

  function automatic logic len_legal(input logic [LEN_BITS-1:0] len);
    return (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
  endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Requester and RAM/IO bus bundle; slave = controller side, master = requesters + memory.
interface mem_arb_ctrl_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32
);
  import mem_arb_ctrl_pkg::*;

  logic [NCH-1:0]          req_i;
  logic [NCH-1:0]          we_i;
  logic [NCH*ADDR_W-1:0]   addr_i;
  logic [NCH*WORD_W-1:0]   wdata_i;
  logic [NCH*LEN_BITS-1:0] len_i;
  logic [WORD_W-1:0]       rdata_o;
  logic [NCH-1:0]          done_o;
  logic                    busy_o;
  logic                    io_buffer_full;
  logic [BYTE_W-1:0]       mem_din;
  logic [BYTE_W-1:0]       mem_dout;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic                    mem_wr;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, len_i, io_buffer_full, mem_din,
    output rdata_o, done_o, busy_o, mem_dout, mem_addr_o, mem_wr
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, len_i, io_buffer_full, mem_din,
    input  rdata_o, done_o, busy_o, mem_dout, mem_addr_o, mem_wr
  );

endinterface

// File: rtl/mem_arb_ctrl_rr.sv
// NCH-wide grant selector: fixed lowest-index priority or round-robin after the last grant.
module mem_arb_ctrl_rr #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned RR    = 0,
  parameter int unsigned IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_i,
  input  logic             upd_i,
  output logic [NCH-1:0]   gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [IDX_W-1:0] ptr_q;
  int unsigned      cand;

  // Search starts just after the last granted channel when round-robin is enabled.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = (RR != 0) ? ((32'(ptr_q) + 32'd1 + i) % NCH) : i;
      if (!any_c && req_i[cand]) begin
        any_c       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (upd_i && any_c) begin
      ptr_q <= idx_c;
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Byte-serial memory controller: arbitrates NCH requesters onto one 8-bit RAM/IO port,
// one 1/2/4-byte load or store at a time.
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned RR     = 0
) (
  input logic           clk,
  input logic           rst,
  mem_arb_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e            state_q;
  txn_t              txn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NCH-1:0]    gnt_q;
  logic [IDX_W-1:0]  ch_q;
  logic [CNT_W-1:0]  iss_q;
  logic [CNT_W-1:0]  rcv_q;
  logic [WORD_W-1:0] acc_q;
  rd_tag_t           pipe_q [RD_LAT];

  logic [WORD_W-1:0] rdata_q;
  logic [NCH-1:0]    done_q;
  logic              busy_q;
  logic [BYTE_W-1:0] dout_q;
  logic [ADDR_W-1:0] maddr_q;
  logic              wr_q;

  logic [NCH-1:0]      elig_c;
  logic [NCH-1:0]      gnt_c;
  logic [IDX_W-1:0]    gnt_idx_c;
  logic                any_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [WORD_W-1:0]   sel_wdata_c;
  logic [LEN_BITS-1:0] sel_len_c;
  logic                sel_we_c;

  // A channel completed last cycle is masked so it must drop its request first.
  assign elig_c = bus.req_i & ~done_q;

  mem_arb_ctrl_rr #(
    .NCH   (NCH),
    .RR    (RR),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (elig_c),
    .upd_i (state_q == ST_IDLE),
    .gnt_c (gnt_c),
    .idx_c (gnt_idx_c),
    .any_c (any_c)
  );

  always_comb begin
    sel_addr_c  = bus.addr_i[32'(gnt_idx_c) * ADDR_W +: ADDR_W];
    sel_wdata_c = bus.wdata_i[32'(gnt_idx_c) * WORD_W +: WORD_W];
    sel_len_c   = bus.len_i[32'(gnt_idx_c) * LEN_BITS +: LEN_BITS];
    sel_we_c    = bus.we_i[gnt_idx_c];
  end

  assign bus.rdata_o    = rdata_q;
  assign bus.done_o     = done_q;
  assign bus.busy_o     = busy_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_addr_o = maddr_q;
  assign bus.mem_wr     = wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      addr_q  <= '0;
      gnt_q   <= '0;
      ch_q    <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      acc_q   <= '0;
      rdata_q <= ZERO_WORD;
      done_q  <= '0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      maddr_q <= '0;
      wr_q    <= MEM_READ;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      done_q <= '0;
      // Read-return pipeline: each issued address surfaces RD_LAT edges later.
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      pipe_q[0] <= '0;
      if (pipe_q[RD_LAT-1].valid) begin
        acc_q[BYTE_W * 32'(pipe_q[RD_LAT-1].idx) +: BYTE_W] <= bus.mem_din;
        rcv_q <= rcv_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (any_c) begin
            gnt_q  <= gnt_c;
            ch_q   <= gnt_idx_c;
            txn_q  <= '{len: sel_len_c, wdata: sel_wdata_c};
            addr_q <= sel_addr_c;
            acc_q  <= '0;
            rcv_q  <= '0;
            iss_q  <= '0;
            if (!len_legal(sel_len_c)) begin
              done_q  <= gnt_c;
              rdata_q <= ZERO_WORD;
            end else if (sel_we_c == MEM_READ) begin
              state_q   <= ST_RD;
              busy_q    <= 1'b1;
              maddr_q   <= sel_addr_c;
              iss_q     <= CNT_W'(1);
              pipe_q[0] <= '{valid: 1'b1, idx: 2'd0};
            end else begin
              state_q <= ST_WR;
              busy_q  <= 1'b1;
              if (!bus.io_buffer_full) begin
                wr_q    <= MEM_WRITE;
                maddr_q <= sel_addr_c;
                dout_q  <= sel_wdata_c[BYTE_W-1:0];
                iss_q   <= CNT_W'(1);
              end
            end
          end
        end

        ST_RD: begin
          if (!bus.req_i[ch_q]) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            maddr_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
          end else if (rcv_q == txn_q.len) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= gnt_q;
            rdata_q <= acc_q;
            maddr_q <= '0;
          end else if (iss_q < txn_q.len) begin
            maddr_q   <= addr_q + ADDR_W'(iss_q);
            iss_q     <= iss_q + CNT_W'(1);
            pipe_q[0] <= '{valid: 1'b1, idx: iss_q[1:0]};
          end else begin
            maddr_q <= '0;
          end
        end

        ST_WR: begin
          if (iss_q == txn_q.len) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= gnt_q;
            wr_q    <= MEM_READ;
            maddr_q <= '0;
            dout_q  <= '0;
          end else if (bus.io_buffer_full) begin
            wr_q    <= MEM_READ;
            maddr_q <= '0;
            dout_q  <= '0;
          end else begin
            wr_q    <= MEM_WRITE;
            maddr_q <= addr_q + ADDR_W'(iss_q);
            dout_q  <= txn_q.wdata[BYTE_W * 32'(iss_q[1:0]) +: BYTE_W];
            iss_q   <= iss_q + CNT_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench: u0 (RD_LAT=1, fixed priority) and u1 (RD_LAT=3, round-robin) against a byte RAM model.
module tb_mem_arb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  ram [0:1023];
  logic [9:0]  a1_d1 = '0;
  logic [9:0]  a1_d2 = '0;
  logic [31:0] wq_addr [$];
  logic [7:0]  wq_data [$];

  always #5 clk = ~clk;

  mem_arb_ctrl_if #(.NCH(2), .ADDR_W(32)) b0 ();
  mem_arb_ctrl_if #(.NCH(2), .ADDR_W(32)) b1 ();

  mem_arb_ctrl #(.NCH(2), .ADDR_W(32), .RD_LAT(1), .RR(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mem_arb_ctrl #(.NCH(2), .ADDR_W(32), .RD_LAT(3), .RR(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // RD_LAT=1: asynchronous read; RD_LAT=3: address delayed two extra cycles.
  assign b0.mem_din = ram[b0.mem_addr_o[9:0]];
  assign b1.mem_din = ram[a1_d2];

  always @(posedge clk) begin
    a1_d1 <= b1.mem_addr_o[9:0];
    a1_d2 <= a1_d1;
  end

  always @(posedge clk) begin
    if (b0.mem_wr) begin
      wq_addr.push_back(b0.mem_addr_o);
      wq_data.push_back(b0.mem_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input int ch, input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] len);
    b0.req_i[ch]            = req;
    b0.we_i[ch]             = we;
    b0.addr_i[ch*32 +: 32]  = addr;
    b0.wdata_i[ch*32 +: 32] = wd;
    b0.len_i[ch*3 +: 3]     = len;
  endtask

  task automatic set1(input int ch, input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] len);
    b1.req_i[ch]            = req;
    b1.we_i[ch]             = we;
    b1.addr_i[ch*32 +: 32]  = addr;
    b1.wdata_i[ch*32 +: 32] = wd;
    b1.len_i[ch*3 +: 3]     = len;
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic [1:0]  exp_done;
    logic [31:0] exp_rdata;

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h040] = 8'hA5; ram[10'h041] = 8'h5A;

    set0(0, 0, 0, 0, 0, 0); set0(1, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0); set1(1, 0, 0, 0, 0, 0);
    b0.io_buffer_full = 1'b0;
    b1.io_buffer_full = 1'b0;

    tick(); tick();
    chk("rst_done",  64'(b0.done_o), 64'h0);
    chk("rst_busy",  64'(b0.busy_o), 64'h0);
    chk("rst_wr",    64'(b0.mem_wr), 64'h0);
    chk("rst_addr",  64'(b0.mem_addr_o), 64'h0);
    chk("rst_rdata", 64'(b0.rdata_o), 64'h0);
    chk("rst_busy1", 64'(b1.busy_o), 64'h0);
    rst = 1'b0;
    tick();

    // T1: ch1 word load @0x100
    set0(1, 1, 0, 32'h100, 0, 3'd4);
    tick();
    chk("t1_addr0", 64'(b0.mem_addr_o), 64'h100);
    chk("t1_busy",  64'(b0.busy_o), 64'h1);
    tick(); tick(); tick();
    chk("t1_addr3", 64'(b0.mem_addr_o), 64'h103);
    chk("t1_rd_wr", 64'(b0.mem_wr), 64'h0);
    tick();
    chk("t1_early_done", 64'(b0.done_o), 64'h0);
    chk("t1_addr_idle",  64'(b0.mem_addr_o), 64'h0);
    tick();
    chk("t1_done",  64'(b0.done_o), 64'h2);
    chk("t1_rdata", 64'(b0.rdata_o), 64'h44332211);
    chk("t1_busy0", 64'(b0.busy_o), 64'h0);
    b0.req_i[1] = 1'b0;
    tick();
    chk("t1_pulse", 64'(b0.done_o), 64'h0);
    chk("t1_hold",  64'(b0.rdata_o), 64'h44332211);

    // T2: ch0 half store with io_buffer_full stall; req dropped mid-store
    set0(0, 1, 1, 32'h20, 32'h0000BEEF, 3'd2);
    tick();
    chk("t2_wr0",   64'(b0.mem_wr), 64'h1);
    chk("t2_addr0", 64'(b0.mem_addr_o), 64'h20);
    chk("t2_dout0", 64'(b0.mem_dout), 64'hEF);
    b0.req_i[0] = 1'b0;
    b0.io_buffer_full = 1'b1;
    tick();
    chk("t2_stall_wr",   64'(b0.mem_wr), 64'h0);
    chk("t2_stall_addr", 64'(b0.mem_addr_o), 64'h0);
    chk("t2_stall_busy", 64'(b0.busy_o), 64'h1);
    tick(); tick();
    chk("t2_stall3_wr", 64'(b0.mem_wr), 64'h0);
    b0.io_buffer_full = 1'b0;
    tick();
    chk("t2_wr1",   64'(b0.mem_wr), 64'h1);
    chk("t2_addr1", 64'(b0.mem_addr_o), 64'h21);
    chk("t2_dout1", 64'(b0.mem_dout), 64'hBE);
    tick();
    chk("t2_done",    64'(b0.done_o), 64'h1);
    chk("t2_wr_end",  64'(b0.mem_wr), 64'h0);
    chk("t2_nwrites", 64'(wq_addr.size()), 64'd2);
    chk("t2_w0", {wq_addr[0], 24'h0, wq_data[0]}, {32'h20, 24'h0, 8'hEF});
    chk("t2_w1", {wq_addr[1], 24'h0, wq_data[1]}, {32'h21, 24'h0, 8'hBE});
    tick();

    // T3a: simultaneous byte loads, fixed priority
    set0(0, 1, 0, 32'h100, 0, 3'd1);
    set0(1, 1, 0, 32'h101, 0, 3'd1);
    tick();
    chk("t3_first_addr", 64'(b0.mem_addr_o), 64'h100);
    tick(); tick();
    chk("t3_done0",  64'(b0.done_o), 64'h1);
    chk("t3_rdata0", 64'(b0.rdata_o), 64'h11);
    b0.req_i[0] = 1'b0;
    tick();
    chk("t3_second_addr", 64'(b0.mem_addr_o), 64'h101);
    chk("t3_second_busy", 64'(b0.busy_o), 64'h1);
    tick(); tick();
    chk("t3_done1",  64'(b0.done_o), 64'h2);
    chk("t3_rdata1", 64'(b0.rdata_o), 64'h22);
    b0.req_i[1] = 1'b0;
    tick();

    // T6a: illegal length store completes next cycle with no access
    set0(1, 1, 1, 32'h30, 32'hFFFFFFFF, 3'd3);
    tick();
    chk("t6_done",  64'(b0.done_o), 64'h2);
    chk("t6_rdata", 64'(b0.rdata_o), 64'h0);
    chk("t6_wr",    64'(b0.mem_wr), 64'h0);
    chk("t6_busy",  64'(b0.busy_o), 64'h0);
    b0.req_i[1] = 1'b0;
    tick();
    chk("t6_pulse",   64'(b0.done_o), 64'h0);
    chk("t6_nwrites", 64'(wq_addr.size()), 64'd2);

    // T4: ch1 read aborted, then ch0 half load
    set0(1, 1, 0, 32'h100, 0, 3'd4);
    tick();
    chk("t4_addr0", 64'(b0.mem_addr_o), 64'h100);
    tick();
    chk("t4_addr1", 64'(b0.mem_addr_o), 64'h101);
    b0.req_i[1] = 1'b0;
    set0(0, 1, 0, 32'h40, 0, 3'd2);
    tick();
    chk("t4_abort_busy", 64'(b0.busy_o), 64'h0);
    chk("t4_abort_addr", 64'(b0.mem_addr_o), 64'h0);
    chk("t4_abort_done", 64'(b0.done_o), 64'h0);
    tick();
    chk("t4_ch0_addr", 64'(b0.mem_addr_o), 64'h40);
    chk("t4_ch0_busy", 64'(b0.busy_o), 64'h1);
    tick();
    chk("t4_nodone_a", 64'(b0.done_o), 64'h0);
    tick();
    chk("t4_nodone_b", 64'(b0.done_o), 64'h0);
    tick();
    chk("t4_done",  64'(b0.done_o), 64'h1);
    chk("t4_rdata", 64'(b0.rdata_o), 64'h5AA5);
    b0.req_i[0] = 1'b0;
    tick();

    // T5: reset during a word store after byte 1
    set0(0, 1, 1, 32'h80, 32'hDDCCBBAA, 3'd4);
    tick();
    chk("t5_dout0", 64'(b0.mem_dout), 64'hAA);
    tick();
    chk("t5_addr1", 64'(b0.mem_addr_o), 64'h81);
    chk("t5_dout1", 64'(b0.mem_dout), 64'hBB);
    rst = 1'b1;
    b0.req_i[0] = 1'b0;
    tick();
    chk("t5_wr",    64'(b0.mem_wr), 64'h0);
    chk("t5_busy",  64'(b0.busy_o), 64'h0);
    chk("t5_addr",  64'(b0.mem_addr_o), 64'h0);
    chk("t5_dout",  64'(b0.mem_dout), 64'h0);
    chk("t5_rdata", 64'(b0.rdata_o), 64'h0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_wr_after", 64'(b0.mem_wr), 64'h0);
    chk("t5_nwrites",  64'(wq_addr.size()), 64'd4);
    chk("t5_last_w", {wq_addr[3], 24'h0, wq_data[3]}, {32'h81, 24'h0, 8'hBB});

    // T3b + T6b: round-robin alternation, RD_LAT=3 byte loads done at grant+4
    for (int r = 0; r < 3; r++) begin
      exp_addr  = (r % 2 == 0) ? 32'h101 : 32'h100;
      exp_done  = (r % 2 == 0) ? 2'b10 : 2'b01;
      exp_rdata = (r % 2 == 0) ? 32'h22 : 32'h11;
      set1(0, 1, 0, 32'h100, 0, 3'd1);
      set1(1, 1, 0, 32'h101, 0, 3'd1);
      tick();
      chk($sformatf("rr%0d_addr", r), 64'(b1.mem_addr_o), 64'(exp_addr));
      chk($sformatf("rr%0d_busy", r), 64'(b1.busy_o), 64'h1);
      tick(); tick(); tick();
      chk($sformatf("rr%0d_early", r), 64'(b1.done_o), 64'h0);
      tick();
      chk($sformatf("rr%0d_done", r), 64'(b1.done_o), 64'(exp_done));
      chk($sformatf("rr%0d_rdata", r), 64'(b1.rdata_o), 64'(exp_rdata));
      b1.req_i = 2'b00;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
